shift_unbuffer: RTL and testbench

//  Parallel-to-serial unpacker: the transmit-side counterpart of the word-collecting shift buffer.

---
 rtl/shift_unbuffer.sv | 91 +++++++++
 tb/tb_shift_unbuffer.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/shift_unbuffer.sv
// Parallel-to-serial unpacker: captures one BUF_SIZE*BUF_WIDTH vector and streams
// its words out MSB-most first over a valid/ready handshake with zero-bubble reload.
module shift_unbuffer #(
  parameter int BUF_SIZE  = 8,
  parameter int BUF_WIDTH = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [BUF_SIZE*BUF_WIDTH-1:0] data_i,
  input  logic                          in_valid_i,
  output logic                          in_ready_o,
  output logic [BUF_WIDTH-1:0]          data_o,
  output logic                          out_valid_o,
  input  logic                          out_ready_i,
  output logic                          last_o
);

  localparam int VEC_W = BUF_SIZE * BUF_WIDTH;
  localparam int CNT_W = $clog2(BUF_SIZE);
  localparam logic [CNT_W-1:0] CNT_PEN = CNT_W'(BUF_SIZE - 2);

  typedef enum logic {IDLE, SEND} state_t;

  state_t             r_state;
  logic [VEC_W-1:0]   r_hold;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_valid;
  logic               r_last;

  logic               w_in_ready;
  logic               w_load;
  logic               w_xfer;

  // A new vector may enter when idle, or when the final word leaves this very cycle.
  assign w_in_ready  = (r_state == IDLE) | (out_ready_i & r_last);
  assign w_load      = in_valid_i & w_in_ready;
  assign w_xfer      = r_valid & out_ready_i;

  assign in_ready_o  = w_in_ready;
  assign out_valid_o = r_valid;
  assign last_o      = r_last;
  // The holding register shifts left, so the current word is always its top slice.
  assign data_o      = r_hold[VEC_W-1 -: BUF_WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_hold  <= '0;
      r_cnt   <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_load) begin
            r_hold  <= data_i;
            r_cnt   <= '0;
            r_valid <= 1'b1;
            r_last  <= 1'b0;
            r_state <= SEND;
          end
        end
        SEND: begin
          if (w_xfer) begin
            if (r_last) begin
              r_cnt  <= '0;
              r_last <= 1'b0;
              if (w_load) begin
                r_hold <= data_i;
              end else begin
                r_hold  <= '0;
                r_valid <= 1'b0;
                r_state <= IDLE;
              end
            end else begin
              r_hold <= {r_hold[VEC_W-BUF_WIDTH-1:0], {BUF_WIDTH{1'b0}}};
              r_cnt  <= r_cnt + CNT_W'(1);
              r_last <= (r_cnt == CNT_PEN);
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_valid <= 1'b0;
          r_last  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_unbuffer.sv
// Directed bench for shift_unbuffer (8 x 32-bit words): ordering, backpressure,
// back-to-back reload, ignored loads, async reset and input capture.
module tb_shift_unbuffer;

  localparam int N = 8;
  localparam int W = 32;

  logic           clk;
  logic           rst_n;
  logic [N*W-1:0] data_i;
  logic           in_valid_i;
  logic           in_ready_o;
  logic [W-1:0]   data_o;
  logic           out_valid_o;
  logic           out_ready_i;
  logic           last_o;

  int total = 0;
  int bad   = 0;

  logic [N*W-1:0] v1, v2, vdead;

  shift_unbuffer #(.BUF_SIZE(N), .BUF_WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .data_i(data_i), .in_valid_i(in_valid_i),
    .in_ready_o(in_ready_o), .data_o(data_o), .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i), .last_o(last_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [N*W-1:0] make_vec(input logic [W-1:0] base);
    logic [N*W-1:0] v;
    v = '0;
    for (int j = 0; j < N; j++) v[W*(N-j)-1 -: W] = base + W'(j);
    return v;
  endfunction

  // Offers vec for one edge with out_ready high; returns at the negedge after the load edge.
  task automatic do_load(input logic [N*W-1:0] vec);
    @(negedge clk);
    data_i = vec; in_valid_i = 1'b1; out_ready_i = 1'b1;
    @(negedge clk);
    in_valid_i = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b0; data_i = '0;
    repeat (2) @(negedge clk);
    #1;
    total++; if (out_valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", out_valid_o); end
    total++; if (last_o !== 1'b0) begin bad++; $display("FAIL reset_last got=%b exp=0", last_o); end
    total++; if (data_o !== '0) begin bad++; $display("FAIL reset_data got=%h exp=0", data_o); end
    total++; if (in_ready_o !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready_o); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single;
    @(negedge clk); #1;
    total++; if (in_ready_o !== 1'b1) begin bad++; $display("FAIL single_idle_ready got=%b exp=1", in_ready_o); end
    do_load(v1);
    for (int k = 0; k < N; k++) begin
      out_ready_i = 1'b1;
      #1;
      total++; if (out_valid_o !== 1'b1) begin bad++; $display("FAIL single_valid k=%0d got=%b exp=1", k, out_valid_o); end
      total++; if (data_o !== W'(k)) begin bad++; $display("FAIL single_data k=%0d got=%h exp=%h", k, data_o, W'(k)); end
      total++; if (last_o !== (k == N-1)) begin bad++; $display("FAIL single_last k=%0d got=%b exp=%b", k, last_o, (k == N-1)); end
      total++; if (in_ready_o !== (k == N-1)) begin bad++; $display("FAIL single_in_ready k=%0d got=%b exp=%b", k, in_ready_o, (k == N-1)); end
      @(negedge clk);
    end
    #1;
    total++; if (out_valid_o !== 1'b0) begin bad++; $display("FAIL single_end_valid got=%b exp=0", out_valid_o); end
    total++; if (in_ready_o !== 1'b1) begin bad++; $display("FAIL single_end_ready got=%b exp=1", in_ready_o); end
  endtask

  task automatic test_backpressure;
    int w, stall, cyc;
    w = 0; stall = 0; cyc = 0;
    do_load(v1);
    while (w < N && cyc < 30) begin
      if ((w == 2 || w == 5) && stall < 3) begin out_ready_i = 1'b0; stall++; end
      else out_ready_i = 1'b1;
      #1;
      total++; if (out_valid_o !== 1'b1) begin bad++; $display("FAIL bp_valid cyc=%0d got=%b exp=1", cyc, out_valid_o); end
      total++; if (data_o !== W'(w)) begin bad++; $display("FAIL bp_data cyc=%0d got=%h exp=%h", cyc, data_o, W'(w)); end
      total++; if (last_o !== (w == N-1)) begin bad++; $display("FAIL bp_last cyc=%0d got=%b exp=%b", cyc, last_o, (w == N-1)); end
      if (out_ready_i) begin w++; stall = 0; end
      cyc++;
      @(negedge clk);
    end
    out_ready_i = 1'b1;
    #1;
    total++; if (cyc !== 14) begin bad++; $display("FAIL bp_cycles got=%0d exp=14", cyc); end
    total++; if (out_valid_o !== 1'b0) begin bad++; $display("FAIL bp_end_valid got=%b exp=0", out_valid_o); end
  endtask

  task automatic test_back_to_back;
    logic [W-1:0] exp_d;
    do_load(v1);
    for (int k = 0; k < 2*N; k++) begin
      out_ready_i = 1'b1;
      in_valid_i  = (k < N);
      data_i      = (k < N) ? v2 : vdead;
      exp_d = (k < N) ? W'(k) : (32'hA0 + W'(k - N));
      #1;
      total++; if (out_valid_o !== 1'b1) begin bad++; $display("FAIL b2b_valid k=%0d got=%b exp=1", k, out_valid_o); end
      total++; if (data_o !== exp_d) begin bad++; $display("FAIL b2b_data k=%0d got=%h exp=%h", k, data_o, exp_d); end
      total++; if (last_o !== (k % N == N-1)) begin bad++; $display("FAIL b2b_last k=%0d got=%b exp=%b", k, last_o, (k % N == N-1)); end
      total++; if (in_ready_o !== (k % N == N-1)) begin bad++; $display("FAIL b2b_in_ready k=%0d got=%b exp=%b", k, in_ready_o, (k % N == N-1)); end
      @(negedge clk);
    end
    in_valid_i = 1'b0;
    #1;
    total++; if (out_valid_o !== 1'b0) begin bad++; $display("FAIL b2b_end_valid got=%b exp=0", out_valid_o); end
  endtask

  task automatic test_ignored_load;
    do_load(v1);
    for (int k = 0; k < N; k++) begin
      out_ready_i = 1'b1;
      in_valid_i  = (k >= 1 && k <= 6) && (k % 2 == 1);
      data_i      = vdead;
      #1;
      total++; if (data_o !== W'(k)) begin bad++; $display("FAIL ign_data k=%0d got=%h exp=%h", k, data_o, W'(k)); end
      if (k >= 1 && k <= 6) begin
        total++; if (in_ready_o !== 1'b0) begin bad++; $display("FAIL ign_in_ready k=%0d got=%b exp=0", k, in_ready_o); end
      end
      @(negedge clk);
    end
    in_valid_i = 1'b0;
    #1;
    total++; if (out_valid_o !== 1'b0) begin bad++; $display("FAIL ign_end_valid got=%b exp=0", out_valid_o); end
  endtask

  task automatic test_reset_mid;
    do_load(v1);
    for (int k = 0; k < 4; k++) begin
      out_ready_i = 1'b1;
      @(negedge clk);
    end
    #1;
    total++; if (data_o !== W'(4)) begin bad++; $display("FAIL rmid_pre_data got=%h exp=4", data_o); end
    rst_n = 1'b0;
    #1;
    total++; if (out_valid_o !== 1'b0) begin bad++; $display("FAIL rmid_valid got=%b exp=0", out_valid_o); end
    total++; if (last_o !== 1'b0) begin bad++; $display("FAIL rmid_last got=%b exp=0", last_o); end
    total++; if (data_o !== '0) begin bad++; $display("FAIL rmid_data got=%h exp=0", data_o); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    total++; if (in_ready_o !== 1'b1) begin bad++; $display("FAIL rmid_in_ready got=%b exp=1", in_ready_o); end
    do_load(v2);
    for (int k = 0; k < N; k++) begin
      out_ready_i = 1'b1;
      #1;
      total++; if (data_o !== 32'hA0 + W'(k)) begin bad++; $display("FAIL rmid_new_data k=%0d got=%h exp=%h", k, data_o, 32'hA0 + W'(k)); end
      @(negedge clk);
    end
  endtask

  task automatic test_capture;
    do_load(v1);
    data_i = vdead;
    for (int k = 0; k < N; k++) begin
      out_ready_i = 1'b1;
      #1;
      total++; if (data_o !== W'(k)) begin bad++; $display("FAIL cap_data k=%0d got=%h exp=%h", k, data_o, W'(k)); end
      @(negedge clk);
    end
    #1;
    total++; if (out_valid_o !== 1'b0) begin bad++; $display("FAIL cap_end_valid got=%b exp=0", out_valid_o); end
  endtask

  initial begin
    v1    = make_vec(32'h0);
    v2    = make_vec(32'hA0);
    vdead = make_vec(32'hDEAD0000);
    test_reset;
    test_single;
    test_backpressure;
    test_back_to_back;
    test_ignored_load;
    test_reset_mid;
    test_capture;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
